// File: rtl/eth_pkg.sv
// eth_pkg
//   Shared definitions for the Ethernet receive front end: the receiver
//   state encoding, CRC-32 constants, header geometry and the preamble/SFD
//   dibit values. Also holds a small helper that maps a header dibit onto
//   its bit position inside the assembled EtherType word.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_DROP
    } rx_state_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    localparam int HEADER_DIBITS     = 56;
    localparam int ETYPE_FIRST_DIBIT = 48;

    localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0] SFD_LAST_DIBIT = 2'b11;

    // The EtherType starts on a byte boundary that is also a multiple of 8
    // dibits (dibit 48), so the low 3 bits of the header count give the
    // offset inside the EtherType field directly. Offsets 0-3 carry the
    // high byte, 4-7 the low byte, each byte arriving LSB-first.
    function automatic logic [3:0] etype_bit_index(input logic [2:0] offset);
        return {~offset[2], offset[1:0], 1'b0};
    endfunction

endpackage

// File: rtl/eth_frame_receiver_crc32_dibit.sv
// crc32_dibit
//   Combinational next-state function of a reflected CRC-32 that consumes
//   two bits per step, dibit[0] first. No final XOR is applied here; the
//   caller decides what to compare against.
//
// Ports
//   crc_in   in  32  current CRC register value
//   dibit    in   2  incoming RMII dibit
//   crc_out  out 32  CRC value after absorbing both bits
module crc32_dibit
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [1:0]  dibit,
    output logic [31:0] crc_out
);

    // Two unrolled bit-serial LFSR steps of the reflected polynomial.
    always_comb begin
        logic [31:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 0; i < 2; i++) begin
            fb = c[0] ^ dibit[i];
            c  = (c >> 1) ^ ({32{fb}} & CRC_POLY);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_frame_receiver.sv
// eth_frame_receiver
//   RMII receive front end. Finds the preamble/SFD, skips the 14-byte MAC
//   header while filtering on EtherType, streams payload dibits out through
//   a delay line deep enough to hold the FCS (so the FCS is never emitted),
//   and reports a per-frame CRC/length verdict when carrier drops.
//
// Ports
//   eth_refclk  in   1  RMII 50 MHz reference clock
//   rst         in   1  synchronous active-high reset
//   crsdv       in   1  RMII carrier-sense / data-valid
//   rxd         in   2  RMII receive dibit, LSB-first within each byte
//   axiov       out  1  payload dibit valid
//   axiod       out  2  payload dibit
//   frame_done  out  1  one-cycle pulse at the end of an accepted frame
//   frame_bad   out  1  frame verdict, valid while frame_done is high
module eth_frame_receiver
    import eth_pkg::*;
#(
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter int          FCS_DIBITS = 16
) (
    input  logic       eth_refclk,
    input  logic       rst,
    input  logic       crsdv,
    input  logic [1:0] rxd,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       frame_done,
    output logic       frame_bad
);

    localparam int FILL_W = $clog2(FCS_DIBITS + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FCS_DIBITS);

    rx_state_t state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] crc_next;
    logic [5:0]  hdr_cnt_q, hdr_cnt_d;
    logic [15:0] etype_q, etype_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [11:0] pay_cnt_q, pay_cnt_d;
    logic [FCS_DIBITS-1:0][1:0] dline_q, dline_d;
    logic        axiov_q, axiov_d;
    logic [1:0]  axiod_q, axiod_d;
    logic        frame_done_q, frame_done_d;
    logic        frame_bad_q, frame_bad_d;

    crc32_dibit u_crc (
        .crc_in  (crc_q),
        .dibit   (rxd),
        .crc_out (crc_next)
    );

    // Next-state logic. Outputs default to 0 each cycle so axiov and
    // frame_done are naturally single-cycle qualified strobes. The delay
    // line index 0 is the newest dibit, index FCS_DIBITS-1 the oldest.
    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        hdr_cnt_d    = hdr_cnt_q;
        etype_d      = etype_q;
        fill_d       = fill_q;
        pay_cnt_d    = pay_cnt_q;
        dline_d      = dline_q;
        axiov_d      = 1'b0;
        axiod_d      = 2'b00;
        frame_done_d = 1'b0;
        frame_bad_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (crsdv) begin
                    state_d = (rxd == PREAMBLE_DIBIT) ? ST_PREAMBLE : ST_DROP;
                end
            end

            ST_PREAMBLE: begin
                if (!crsdv) begin
                    state_d = ST_IDLE;
                end else if (rxd == SFD_LAST_DIBIT) begin
                    state_d   = ST_HEADER;
                    crc_d     = CRC_INIT;
                    hdr_cnt_d = '0;
                    fill_d    = '0;
                    pay_cnt_d = '0;
                end else if (rxd != PREAMBLE_DIBIT) begin
                    state_d = ST_DROP;
                end
            end

            ST_HEADER: begin
                if (!crsdv) begin
                    state_d = ST_IDLE;
                end else begin
                    crc_d     = crc_next;
                    hdr_cnt_d = hdr_cnt_q + 6'd1;
                    if (hdr_cnt_q >= 6'(ETYPE_FIRST_DIBIT)) begin
                        etype_d[etype_bit_index(hdr_cnt_q[2:0]) +: 2] = rxd;
                    end
                    // The comparison uses etype_d so the final dibit of the
                    // EtherType is included in the same cycle it arrives.
                    if (hdr_cnt_q == 6'(HEADER_DIBITS - 1)) begin
                        state_d = (etype_d == ETHERTYPE) ? ST_PAYLOAD : ST_DROP;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (!crsdv) begin
                    // Whatever is still in the delay line is the FCS and is
                    // simply abandoned; the CRC register already covers it.
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                    frame_bad_d  = (crc_q != CRC_RESIDUE)
                                 || (fill_q != FILL_FULL)
                                 || (pay_cnt_q[1:0] != 2'b00);
                end else begin
                    crc_d   = crc_next;
                    dline_d = {dline_q[FCS_DIBITS-2:0], rxd};
                    if (fill_q == FILL_FULL) begin
                        axiov_d   = 1'b1;
                        axiod_d   = dline_q[FCS_DIBITS-1];
                        pay_cnt_d = pay_cnt_q + 12'd1;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
            end

            ST_DROP: begin
                if (!crsdv) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_DROP;
            end
        endcase
    end

    // State and output registers. Reset parks the receiver in DROP so a
    // frame already on the wire when reset releases is ignored until the
    // carrier drops.
    always_ff @(posedge eth_refclk) begin
        if (rst) begin
            state_q      <= ST_DROP;
            crc_q        <= CRC_INIT;
            hdr_cnt_q    <= '0;
            etype_q      <= '0;
            fill_q       <= '0;
            pay_cnt_q    <= '0;
            dline_q      <= '0;
            axiov_q      <= 1'b0;
            axiod_q      <= 2'b00;
            frame_done_q <= 1'b0;
            frame_bad_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            hdr_cnt_q    <= hdr_cnt_d;
            etype_q      <= etype_d;
            fill_q       <= fill_d;
            pay_cnt_q    <= pay_cnt_d;
            dline_q      <= dline_d;
            axiov_q      <= axiov_d;
            axiod_q      <= axiod_d;
            frame_done_q <= frame_done_d;
            frame_bad_q  <= frame_bad_d;
        end
    end

    assign axiov      = axiov_q;
    assign axiod      = axiod_q;
    assign frame_done = frame_done_q;
    assign frame_bad  = frame_bad_q;

endmodule

// File: tb/tb_eth_frame_receiver.sv
// tb_eth_frame_receiver
//   Self-checking bench for eth_frame_receiver. Frames are built as byte
//   lists (random MAC addresses, chosen EtherType, payload, FCS), turned
//   into RMII dibits and driven in. The expected payload stream and the
//   expected verdict are derived from the frame contents: everything after
//   the 56 header dibits except the trailing 16 is payload, and a frame is
//   good only when the bit-serial CRC over all post-SFD bits leaves the
//   standard residue, at least 16 dibits followed the header and the
//   payload is a whole number of bytes.
module tb_eth_frame_receiver;

    logic       eth_refclk = 1'b0;
    logic       rst;
    logic       crsdv;
    logic [1:0] rxd;
    logic       axiov;
    logic [1:0] axiod;
    logic       frame_done;
    logic       frame_bad;

    eth_frame_receiver #(
        .ETHERTYPE  (16'h88B5),
        .FCS_DIBITS (16)
    ) dut (
        .eth_refclk (eth_refclk),
        .rst        (rst),
        .crsdv      (crsdv),
        .rxd        (rxd),
        .axiov      (axiov),
        .axiod      (axiod),
        .frame_done (frame_done),
        .frame_bad  (frame_bad)
    );

    always #10 eth_refclk = ~eth_refclk;

    int totalChecks = 0;
    int badChecks   = 0;

    // Observed side, accumulated for the whole run.
    logic [1:0] gotQ[$];
    int doneCnt    = 0;
    int badSum     = 0;
    int overlapCnt = 0;

    // Expected side, accumulated for the whole run.
    logic [1:0] expQ[$];
    int expDone    = 0;
    int expBadSum  = 0;
    int checkedIdx = 0;

    logic [1:0] frameQ[$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor, sampling on the inactive edge.
    always @(negedge eth_refclk) begin
        if (axiov) gotQ.push_back(axiod);
        if (frame_done) begin
            doneCnt++;
            if (frame_bad) badSum++;
            if (axiov) overlapCnt++;
        end
    end

    task automatic applyStimulus(input logic c, input logic [1:0] d);
        crsdv = c;
        rxd   = d;
        @(posedge eth_refclk);
        #1;
    endtask

    function automatic logic [31:0] crcBit(input logic [31:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
        return c;
    endfunction

    // Builds frameQ: 12 random MAC bytes, EtherType, payload, FCS.
    // pattern 0 gives i % 256, otherwise random bytes. corruptIdx >= 0
    // flips bit 0 of that payload byte after the FCS is computed. trunc
    // removes that many dibits from the end.
    task automatic buildFrame(input logic [15:0] etype, input int nPay, input int pattern,
                              input int corruptIdx, input int trunc);
        logic [7:0]  bytesQ[$];
        logic [31:0] crc;
        logic [31:0] fcs;
        logic [7:0]  b;
        bytesQ = {};
        for (int i = 0; i < 12; i++) bytesQ.push_back(8'($urandom_range(0, 255)));
        bytesQ.push_back(etype[15:8]);
        bytesQ.push_back(etype[7:0]);
        for (int i = 0; i < nPay; i++)
            bytesQ.push_back(pattern == 0 ? 8'(i % 256) : 8'($urandom_range(0, 255)));
        crc = 32'hFFFFFFFF;
        foreach (bytesQ[i])
            for (int k = 0; k < 8; k++) crc = crcBit(crc, bytesQ[i][k]);
        fcs = ~crc;
        if (corruptIdx >= 0) bytesQ[14 + corruptIdx] = bytesQ[14 + corruptIdx] ^ 8'h01;
        bytesQ.push_back(fcs[7:0]);
        bytesQ.push_back(fcs[15:8]);
        bytesQ.push_back(fcs[23:16]);
        bytesQ.push_back(fcs[31:24]);
        frameQ = {};
        foreach (bytesQ[i]) begin
            b = bytesQ[i];
            for (int k = 0; k < 4; k++) frameQ.push_back(b[2*k +: 2]);
        end
        repeat (trunc) void'(frameQ.pop_back());
    endtask

    // Reference model for the frame currently in frameQ.
    task automatic expectFrame(input logic [15:0] etype);
        int n;
        logic [31:0] crc;
        logic bad;
        if (etype != 16'h88B5 || frameQ.size() < 56) return;
        n = frameQ.size() - 56;
        for (int i = 0; i < n - 16; i++) expQ.push_back(frameQ[56 + i]);
        crc = 32'hFFFFFFFF;
        foreach (frameQ[i]) begin
            crc = crcBit(crc, frameQ[i][0]);
            crc = crcBit(crc, frameQ[i][1]);
        end
        bad = (crc != 32'hDEBB20E3) || (n < 16) || (((n - 16) % 4) != 0);
        expDone++;
        if (bad) expBadSum++;
    endtask

    task automatic sendPreamble();
        repeat (31) applyStimulus(1'b1, 2'b01);
        applyStimulus(1'b1, 2'b11);
    endtask

    task automatic sendFrame(input int gap);
        sendPreamble();
        foreach (frameQ[i]) applyStimulus(1'b1, frameQ[i]);
        repeat (gap) applyStimulus(1'b0, 2'($urandom_range(0, 3)));
    endtask

    task automatic checkBatch(input string tag);
        int diffs;
        int lim;
        repeat (3) applyStimulus(1'b0, 2'b00);
        checkOutput({tag, "_count"}, gotQ.size(), expQ.size());
        lim = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
        diffs = 0;
        for (int i = checkedIdx; i < lim; i++)
            if (gotQ[i] !== expQ[i]) diffs++;
        checkOutput({tag, "_data"}, diffs, 0);
        checkedIdx = lim;
        checkOutput({tag, "_done"}, doneCnt, expDone);
        checkOutput({tag, "_bad"}, badSum, expBadSum);
    endtask

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] et;
        int nPay, corr, trunc;

        // Reset with carrier already active on the wire.
        rst   = 1'b1;
        crsdv = 1'b1;
        rxd   = 2'b01;
        repeat (3) @(posedge eth_refclk);
        @(negedge eth_refclk);
        checkOutput("reset_axiov", axiov, 0);
        checkOutput("reset_axiod", axiod, 0);
        checkOutput("reset_done", frame_done, 0);
        checkOutput("reset_bad", frame_bad, 0);

        // Release reset mid-carrier: this frame must be ignored entirely.
        @(posedge eth_refclk);
        #1;
        rst = 1'b0;
        buildFrame(16'h88B5, 64, 1, -1, 0);
        sendFrame(4);
        checkBatch("start_in_drop");

        $display("[TB] valid 1024-byte frame");
        buildFrame(16'h88B5, 1024, 0, -1, 0);
        expectFrame(16'h88B5);
        sendFrame(4);
        checkBatch("valid");

        $display("[TB] corrupted payload byte 100");
        buildFrame(16'h88B5, 1024, 0, 100, 0);
        expectFrame(16'h88B5);
        sendFrame(4);
        checkBatch("corrupt");

        $display("[TB] foreign EtherType");
        buildFrame(16'h0800, 64, 1, -1, 0);
        expectFrame(16'h0800);
        sendFrame(4);
        checkBatch("etype");

        $display("[TB] short frames");
        buildFrame(16'h88B5, 3, 1, -1, 0);
        expectFrame(16'h88B5);
        sendFrame(4);
        checkBatch("runt3");
        buildFrame(16'h88B5, 3, 1, -1, 2);
        expectFrame(16'h88B5);
        sendFrame(4);
        checkBatch("runt_short2");
        buildFrame(16'h88B5, 0, 1, -1, 2);
        expectFrame(16'h88B5);
        sendFrame(4);
        checkBatch("under16");

        $display("[TB] reset after 500 payload dibits");
        buildFrame(16'h88B5, 1024, 0, -1, 0);
        sendPreamble();
        for (int i = 0; i < 556; i++) applyStimulus(1'b1, frameQ[i]);
        for (int i = 0; i < 484; i++) expQ.push_back(frameQ[56 + i]);
        rst = 1'b1;
        applyStimulus(1'b1, frameQ[556]);
        checkOutput("rst_axiov", axiov, 0);
        rst = 1'b0;
        for (int i = 557; i < frameQ.size(); i++) applyStimulus(1'b1, frameQ[i]);
        applyStimulus(1'b0, 2'b00);
        checkBatch("mid_reset");
        buildFrame(16'h88B5, 1024, 0, -1, 0);
        expectFrame(16'h88B5);
        sendFrame(4);
        checkBatch("after_reset");

        $display("[TB] back-to-back frames");
        buildFrame(16'h88B5, 40, 1, -1, 0);
        expectFrame(16'h88B5);
        sendFrame(1);
        buildFrame(16'h88B5, 52, 1, -1, 0);
        expectFrame(16'h88B5);
        sendFrame(1);
        checkBatch("b2b");

        $display("[TB] randomized frames");
        for (int f = 0; f < 25; f++) begin
            et    = ($urandom_range(0, 3) != 0) ? 16'h88B5 : 16'($urandom_range(0, 65535));
            nPay  = $urandom_range(0, 48);
            corr  = (nPay > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, nPay - 1) : -1;
            trunc = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            buildFrame(et, nPay, 1, corr, trunc);
            expectFrame(et);
            sendFrame($urandom_range(1, 3));
        end
        checkBatch("random");

        checkOutput("done_with_axiov", overlapCnt, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
